// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 1736;
  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned DATA_BITS            = 8;
  localparam logic        LINE_IDLE            = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word-visible read data for the UART transmitter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     count
);

  logic [DATA_BITS-1:0] mem_q [1 << FIFO_AW];
  logic [DATA_BITS-1:0] mem_d [1 << FIFO_AW];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 wr_ok;
  logic                 rd_ok;

  // Pointers wrap modulo depth; the extra count bit separates full from empty.
  assign full    = count_q[FIFO_AW];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter fed by a byte FIFO over a valid/ready handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ct_UartTx,
  output logic             tx_busy,
  output logic [FIFO_AW:0] tx_count
);

  localparam int unsigned      BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 line_q, line_d;

  logic                 push;
  logic                 fifo_rd_en;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;

  assign tx_ready  = !fifo_full && !reset;
  assign push      = tx_valid && tx_ready;
  assign bit_end   = (baud_q == BAUD_LAST);
  assign ct_UartTx = line_q;
  assign tx_busy   = (state_q != IDLE) || (tx_count != '0);

  uart_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (CLK),
    .rst     (reset),
    .wr_en   (push),
    .wr_data (tx_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (tx_count)
  );

  // The line register follows the current state, so the serial output lags the
  // FSM by one cycle while every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d    = state_q;
    baud_d     = bit_end ? '0 : baud_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    line_d     = LINE_IDLE;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_d    = fifo_rd_data;
          state_d    = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        line_d = shift_q[0];
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            shift_d    = fifo_rd_data;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      line_q    <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
    end
  end

endmodule
